// File: rtl/eight_bit_adder_unit_if.sv
// Operand, sum and condition-flag bundle between the B/C registers, the adder and the sequencer.
// No valid/ready handshake: operands are sampled continuously, and flag_en is a one-cycle capture strobe.
interface eight_bit_adder_unit_if;
   logic [7:0] b;
   logic [7:0] c;
   logic       flag_en;
   logic [7:0] adder_out;
   logic       carry;
   logic [7:0] sum_q;
   logic       carry_q;
   logic       zero_q;
   logic       sign_q;

   modport master (
      output b, c, flag_en,
      input  adder_out, carry, sum_q, carry_q, zero_q, sign_q
   );

   modport slave (
      input  b, c, flag_en,
      output adder_out, carry, sum_q, carry_q, zero_q, sign_q
   );
endinterface

// File: rtl/eight_bit_adder_unit.sv
// Ripple-carry 8-bit adder for the relay ALU with a clocked sum/carry/zero/sign flag register.
// The sum path is purely combinational; the flags load on clk when flag_en is high.
module eight_bit_adder_unit (
   input  logic                  clk,
   input  logic                  reset,
   eight_bit_adder_unit_if.slave bus
);
   localparam int WIDTH = 8;

   logic [WIDTH-1:0] s;
   logic [WIDTH:0]   k;

   logic [WIDTH-1:0] sum_d, sum_q;
   logic             carry_d, carry_q;
   logic             zero_d, zero_q;
   logic             sign_d, sign_q;

   // One full adder per bit, carry rippling from bit 0 upward with no carry-in.
   always_comb begin
      s    = '0;
      k    = '0;
      k[0] = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         s[i]   = bus.b[i] ^ bus.c[i] ^ k[i];
         k[i+1] = (bus.b[i] & bus.c[i]) | (k[i] & (bus.b[i] ^ bus.c[i]));
      end
   end

   assign bus.adder_out = s;
   assign bus.carry     = k[WIDTH];

   always_comb begin
      sum_d   = sum_q;
      carry_d = carry_q;
      zero_d  = zero_q;
      sign_d  = sign_q;
      if (bus.flag_en) begin
         sum_d   = s;
         carry_d = k[WIDTH];
         zero_d  = (s == '0);
         sign_d  = s[WIDTH-1];
      end
   end

   // Reset state reports a zero result: sum 0, zero flag set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sum_q   <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b1;
         sign_q  <= 1'b0;
      end else begin
         sum_q   <= sum_d;
         carry_q <= carry_d;
         zero_q  <= zero_d;
         sign_q  <= sign_d;
      end
   end

   assign bus.sum_q   = sum_q;
   assign bus.carry_q = carry_q;
   assign bus.zero_q  = zero_q;
   assign bus.sign_q  = sign_q;
endmodule

// File: tb/tb_eight_bit_adder_unit.sv
// Directed-vector bench for eight_bit_adder_unit: combinational sum, flag capture, hold and async reset.
module tb_eight_bit_adder_unit;
   logic clk;
   logic reset;
   int   checks;
   int   failures;

   eight_bit_adder_unit_if bus ();

   eight_bit_adder_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive_ops(input logic [7:0] b_v, input logic [7:0] c_v, input logic en);
      @(negedge clk);
      bus.b       = b_v;
      bus.c       = c_v;
      bus.flag_en = en;
   endtask

   task automatic clock_once();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset       = 1'b1;
      bus.b       = 8'h00;
      bus.c       = 8'h00;
      bus.flag_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({bus.sum_q, bus.carry_q, bus.zero_q, bus.sign_q} !== {8'h00, 1'b0, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL reset_flags got sum=%h c=%b z=%b s=%b want sum=00 c=0 z=1 s=0",
                  bus.sum_q, bus.carry_q, bus.zero_q, bus.sign_q);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_directed();
      logic [7:0] bv [4] = '{8'h00, 8'hFF, 8'h7F, 8'hFF};
      logic [7:0] cv [4] = '{8'h01, 8'h01, 8'h01, 8'hFF};
      logic [8:0] ev [4] = '{9'h001, 9'h100, 9'h080, 9'h1FE};
      for (int i = 0; i < 4; i++) begin
         drive_ops(bv[i], cv[i], 1'b0);
         #1;
         checks++;
         if ({bus.carry, bus.adder_out} !== ev[i]) begin
            failures++;
            $display("FAIL directed_sum[%0d] got %h want %h", i, {bus.carry, bus.adder_out}, ev[i]);
         end
      end
   endtask

   task automatic test_exhaustive();
      int bad;
      logic [8:0] ref_sum;
      bad = 0;
      for (int i = 0; i < 256; i++) begin
         for (int j = 0; j < 256; j++) begin
            bus.b = i[7:0];
            bus.c = j[7:0];
            #1;
            ref_sum = {1'b0, i[7:0]} + {1'b0, j[7:0]};
            if ({bus.carry, bus.adder_out} !== ref_sum) bad++;
         end
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL exhaustive_sum got %0d wrong pairs want 0", bad);
      end
   endtask

   task automatic test_capture();
      // 00+01: sum 01, no carry, not zero, positive
      drive_ops(8'h00, 8'h01, 1'b1);
      clock_once();
      checks++;
      if ({bus.sum_q, bus.carry_q, bus.zero_q, bus.sign_q} !== {8'h01, 1'b0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL capture_00_01 got sum=%h c=%b z=%b s=%b want 01/0/0/0",
                  bus.sum_q, bus.carry_q, bus.zero_q, bus.sign_q);
      end
      // FF+01: wraps to 00 with carry, zero set
      drive_ops(8'hFF, 8'h01, 1'b1);
      clock_once();
      checks++;
      if ({bus.sum_q, bus.carry_q, bus.zero_q, bus.sign_q} !== {8'h00, 1'b1, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL capture_ff_01 got sum=%h c=%b z=%b s=%b want 00/1/1/0",
                  bus.sum_q, bus.carry_q, bus.zero_q, bus.sign_q);
      end
   endtask

   task automatic test_back_to_back();
      // 7F+01 then FF+FF on consecutive edges
      drive_ops(8'h7F, 8'h01, 1'b1);
      clock_once();
      checks++;
      if ({bus.sum_q, bus.carry_q, bus.zero_q, bus.sign_q} !== {8'h80, 1'b0, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL b2b_7f_01 got sum=%h c=%b z=%b s=%b want 80/0/0/1",
                  bus.sum_q, bus.carry_q, bus.zero_q, bus.sign_q);
      end
      drive_ops(8'hFF, 8'hFF, 1'b1);
      clock_once();
      checks++;
      if ({bus.sum_q, bus.carry_q, bus.zero_q, bus.sign_q} !== {8'hFE, 1'b1, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL b2b_ff_ff got sum=%h c=%b z=%b s=%b want fe/1/0/1",
                  bus.sum_q, bus.carry_q, bus.zero_q, bus.sign_q);
      end
   endtask

   task automatic test_hold();
      logic [7:0] hb [3] = '{8'h12, 8'h00, 8'hA0};
      logic [7:0] hc [3] = '{8'h34, 8'h00, 8'hA0};
      logic [8:0] hs [3] = '{9'h046, 9'h000, 9'h140};
      // registers hold FE/1/0/1 from the previous capture
      for (int i = 0; i < 3; i++) begin
         drive_ops(hb[i], hc[i], 1'b0);
         #1;
         checks++;
         if ({bus.carry, bus.adder_out} !== hs[i]) begin
            failures++;
            $display("FAIL hold_comb[%0d] got %h want %h", i, {bus.carry, bus.adder_out}, hs[i]);
         end
         clock_once();
         checks++;
         if ({bus.sum_q, bus.carry_q, bus.zero_q, bus.sign_q} !== {8'hFE, 1'b1, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL hold_regs[%0d] got sum=%h c=%b z=%b s=%b want fe/1/0/1",
                     i, bus.sum_q, bus.carry_q, bus.zero_q, bus.sign_q);
         end
      end
   endtask

   task automatic test_async_reset();
      drive_ops(8'h80, 8'h80, 1'b1);
      clock_once();
      checks++;
      if ({bus.sum_q, bus.carry_q, bus.zero_q, bus.sign_q} !== {8'h00, 1'b1, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL pre_reset_capture got sum=%h c=%b z=%b s=%b want 00/1/1/0",
                  bus.sum_q, bus.carry_q, bus.zero_q, bus.sign_q);
      end
      drive_ops(8'hC0, 8'h01, 1'b1);
      clock_once();
      // mid-cycle, away from any edge
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({bus.sum_q, bus.carry_q, bus.zero_q, bus.sign_q} !== {8'h00, 1'b0, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL async_reset got sum=%h c=%b z=%b s=%b want 00/0/1/0",
                  bus.sum_q, bus.carry_q, bus.zero_q, bus.sign_q);
      end
      bus.b = 8'h55;
      bus.c = 8'hAA;
      #1;
      checks++;
      if ({bus.carry, bus.adder_out} !== 9'h0FF) begin
         failures++;
         $display("FAIL comb_during_reset got %h want 0ff", {bus.carry, bus.adder_out});
      end
      @(negedge clk);
      reset       = 1'b0;
      bus.flag_en = 1'b0;
      clock_once();
      checks++;
      if ({bus.sum_q, bus.carry_q, bus.zero_q, bus.sign_q} !== {8'h00, 1'b0, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL post_reset_idle got sum=%h c=%b z=%b s=%b want 00/0/1/0",
                  bus.sum_q, bus.carry_q, bus.zero_q, bus.sign_q);
      end
      drive_ops(8'h55, 8'hAA, 1'b1);
      clock_once();
      checks++;
      if ({bus.sum_q, bus.carry_q, bus.zero_q, bus.sign_q} !== {8'hFF, 1'b0, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL first_capture got sum=%h c=%b z=%b s=%b want ff/0/0/1",
                  bus.sum_q, bus.carry_q, bus.zero_q, bus.sign_q);
      end
      bus.flag_en = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_directed();
      test_exhaustive();
      test_capture();
      test_back_to_back();
      test_hold();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
